// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types and constants for the sequential ALU core.
//   alu_op_e     - 3-bit opcode encoding (ADD..MUL)
//   alu_state_e  - control FSM states
//   FLAG_*       - bit positions inside the 4-bit {C, V, N, Z} flags vector
//   pack_flags() - assembles a flags vector from individual bits
package alu_seq_pkg;

    localparam int unsigned OP_W    = 3;
    localparam int unsigned FLAGS_W = 4;

    localparam int unsigned FLAG_C = 3;
    localparam int unsigned FLAG_V = 2;
    localparam int unsigned FLAG_N = 1;
    localparam int unsigned FLAG_Z = 0;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_MUL = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2
    } alu_state_e;

    // Place individual flag bits at their fixed positions.
    function automatic logic [FLAGS_W-1:0] pack_flags(
        input logic c,
        input logic v,
        input logic n,
        input logic z
    );
        logic [FLAGS_W-1:0] f;
        f         = '0;
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        return f;
    endfunction

endpackage

// File: rtl/alu_seq_mul.sv
// alu_seq_mul: iterative shift-add multiplier, one partial-product step per
// cycle. Only instantiated when ALU_SEQ_MUL_EN is defined.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : capture mcand/mplier and clear the iteration counter
//   step       : perform one shift-add iteration and bump the counter
//   mcand      : multiplicand (WIDTH)
//   mplier     : multiplier (WIDTH)
//   product    : running / final 2*WIDTH product
//   count      : iterations completed since load
module alu_seq_mul
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic                    step,
    input  logic [WIDTH-1:0]        mcand,
    input  logic [WIDTH-1:0]        mplier,
    output logic [2*WIDTH-1:0]      product,
    output logic [$clog2(WIDTH):0]  count
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] prod_q,  prod_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [WIDTH:0]     partial;

    // Upper half accumulates the multiplicand whenever the current LSB of the
    // multiplier (kept in the lower half) is set; the whole register then
    // shifts right so the next multiplier bit becomes the LSB.
    always_comb begin
        mcand_d = mcand_q;
        prod_d  = prod_q;
        cnt_d   = cnt_q;
        partial = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                + ({(WIDTH+1){prod_q[0]}} & {1'b0, mcand_q});
        if (load) begin
            mcand_d = mcand;
            prod_d  = {{WIDTH{1'b0}}, mplier};
            cnt_d   = '0;
        end else if (step) begin
            prod_d  = {partial, prod_q[WIDTH-1:1]};
            cnt_d   = cnt_q + CNT_W'(1);
        end
    end

    // Multiplier state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
        end else begin
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
            cnt_q   <= cnt_d;
        end
    end

    assign product = prod_q;
    assign count   = cnt_q;

endmodule

// File: rtl/alu_seq_core.sv
// alu_seq_core: sequential ALU with start/busy/done handshake, registered
// result/flags, an accumulator for chained operations and an optional
// iterative multiplier.
// Build option: define ALU_SEQ_MUL_EN to build the shift-add multiplier;
// without it op=111 completes in one cycle with a zero result and Z set.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   ena        : global enable; low freezes every register
//   start      : operation request, accepted when idle and enabled
//   op         : opcode (see alu_op_e)
//   use_acc    : take operand A from the accumulator instead of a
//   a, b       : operands; shift amount is b[$clog2(WIDTH)-1:0]
//   result     : low result
//   result_hi  : high half of the MUL product, 0 otherwise
//   flags      : {C, V, N, Z}
//   busy       : operation in flight
//   done       : one-cycle completion pulse
module alu_seq_core
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               start,
    input  logic [OP_W-1:0]    op,
    input  logic               use_acc,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [WIDTH-1:0]   result,
    output logic [WIDTH-1:0]   result_hi,
    output logic [FLAGS_W-1:0] flags,
    output logic               busy,
    output logic               done
);

    localparam int unsigned SH_W = $clog2(WIDTH);

    alu_state_e         state_q, state_d;
    alu_op_e            op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [WIDTH-1:0]   result_hi_q, result_hi_d;
    logic [FLAGS_W-1:0] flags_q, flags_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   opa_sel;

    logic [SH_W-1:0]    sh_amt;
    logic [WIDTH:0]     add_x;
    logic [WIDTH:0]     sub_x;
    logic [WIDTH:0]     shl_x;
    logic [WIDTH:0]     shr_x;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c;
    logic               alu_v;
    logic [FLAGS_W-1:0] alu_flags;

    // An op can only be accepted while idle, so no completion can coincide
    // with an accept; acc_q already holds the latest completed result.
    assign opa_sel = use_acc ? acc_q : a;

`ifdef ALU_SEQ_MUL_EN
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    logic               mul_load;
    logic               mul_step;
    logic [2*WIDTH-1:0] mul_prod;
    logic [CNT_W-1:0]   mul_count;
    logic [WIDTH-1:0]   mul_hi;

    alu_seq_mul #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (mul_load),
        .step    (mul_step),
        .mcand   (opa_sel),
        .mplier  (b),
        .product (mul_prod),
        .count   (mul_count)
    );

    assign mul_hi = mul_prod[2*WIDTH-1:WIDTH];
`endif

    // Single-cycle datapath on the latched operands.
    always_comb begin
        sh_amt  = b_q[SH_W-1:0];
        add_x   = {1'b0, a_q} + {1'b0, b_q};
        sub_x   = {1'b0, a_q} - {1'b0, b_q};
        // Extra bit on the outgoing side catches the last bit shifted out.
        shl_x   = {1'b0, a_q} << sh_amt;
        shr_x   = {a_q, 1'b0} >> sh_amt;
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op_q)
            OP_ADD: begin
                alu_res = add_x[WIDTH-1:0];
                alu_c   = add_x[WIDTH];
                alu_v   = (a_q[WIDTH-1] == b_q[WIDTH-1])
                       && (add_x[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = sub_x[WIDTH-1:0];
                alu_c   = sub_x[WIDTH];
                alu_v   = (a_q[WIDTH-1] != b_q[WIDTH-1])
                       && (sub_x[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_AND: alu_res = a_q & b_q;
            OP_OR:  alu_res = a_q | b_q;
            OP_XOR: alu_res = a_q ^ b_q;
            OP_SHL: begin
                alu_res = shl_x[WIDTH-1:0];
                alu_c   = shl_x[WIDTH];
            end
            OP_SHR: begin
                alu_res = shr_x[WIDTH:1];
                alu_c   = shr_x[0];
            end
            // MUL without a multiplier: zero result, so Z=1 and C=V=N=0.
            default: alu_res = '0;
        endcase
        alu_flags = pack_flags(alu_c, alu_v, alu_res[WIDTH-1], alu_res == '0);
    end

    // Next-state and output register logic.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        flags_d     = flags_q;
        busy_d      = busy_q;
        done_d      = done_q;
`ifdef ALU_SEQ_MUL_EN
        mul_load    = 1'b0;
        mul_step    = 1'b0;
`endif
        if (ena) begin
            done_d = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        op_d = alu_op_e'(op);
                        a_d  = opa_sel;
                        b_d  = b;
`ifdef ALU_SEQ_MUL_EN
                        if (alu_op_e'(op) == OP_MUL) begin
                            state_d  = ST_MUL;
                            mul_load = 1'b1;
                        end else begin
                            state_d  = ST_EXEC;
                        end
`else
                        state_d = ST_EXEC;
`endif
                    end
                end
                ST_EXEC: begin
                    result_d    = alu_res;
                    result_hi_d = '0;
                    flags_d     = alu_flags;
                    acc_d       = alu_res;
                    done_d      = 1'b1;
                    state_d     = ST_IDLE;
                end
`ifdef ALU_SEQ_MUL_EN
                ST_MUL: begin
                    // Completion takes one edge after the last iteration.
                    if (mul_count == CNT_W'(WIDTH)) begin
                        result_d    = mul_prod[WIDTH-1:0];
                        result_hi_d = mul_hi;
                        flags_d     = pack_flags(|mul_hi, |mul_hi,
                                                 mul_prod[WIDTH-1],
                                                 mul_prod == '0);
                        acc_d       = mul_prod[WIDTH-1:0];
                        done_d      = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        mul_step = 1'b1;
                    end
                end
`endif
                default: state_d = ST_IDLE;
            endcase
            busy_d = (state_d != ST_IDLE);
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_ADD;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            result_q    <= '0;
            result_hi_q <= '0;
            flags_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            flags_q     <= flags_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign flags     = flags_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_alu_seq_core.sv
// tb_alu_seq_core: directed bench for alu_seq_core (WIDTH=8) with a
// cycle-level reference model and literal expectations per operation.
module tb_alu_seq_core;

    localparam int unsigned W = 8;
`ifdef ALU_SEQ_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic         clk     = 1'b0;
    logic         rst_n   = 1'b0;
    logic         ena     = 1'b1;
    logic         start   = 1'b0;
    logic [2:0]   op      = 3'd0;
    logic         use_acc = 1'b0;
    logic [W-1:0] a       = '0;
    logic [W-1:0] b       = '0;
    logic [W-1:0] result;
    logic [W-1:0] result_hi;
    logic [3:0]   flags;
    logic         busy;
    logic         done;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;
    int poke_at  = 0;
    int ena_at   = 0;
    int ena_len  = 0;

    alu_seq_core #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .start     (start),
        .op        (op),
        .use_acc   (use_acc),
        .a         (a),
        .b         (b),
        .result    (result),
        .result_hi (result_hi),
        .flags     (flags),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic [3:0]   flags;
    } exp_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    // Arithmetic reference for one operation, straight from the flag rules.
    function automatic exp_t ref_op(input int o, input int x, input int y);
        exp_t e;
        int   s, ss, sx, sy, sh, p;
        bit   c, v, z;
        e  = '0;
        c  = 1'b0;
        v  = 1'b0;
        p  = 0;
        sx = (x >= (1 << (W-1))) ? x - (1 << W) : x;
        sy = (y >= (1 << (W-1))) ? y - (1 << W) : y;
        sh = y % W;
        case (o)
            0: begin
                s = x + y; e.res = W'(s); c = (s >= (1 << W));
                ss = sx + sy; v = (ss >= (1 << (W-1))) || (ss < -(1 << (W-1)));
            end
            1: begin
                s = x - y; e.res = W'(s); c = (x < y);
                ss = sx - sy; v = (ss >= (1 << (W-1))) || (ss < -(1 << (W-1)));
            end
            2: e.res = W'(x & y);
            3: e.res = W'(x | y);
            4: e.res = W'(x ^ y);
            5: begin
                e.res = W'(x << sh);
                c = (sh != 0) && (((x >> (W - sh)) & 1) == 1);
            end
            6: begin
                e.res = W'(x >> sh);
                c = (sh != 0) && (((x >> (sh - 1)) & 1) == 1);
            end
            default: begin
                p = MUL_EN ? x * y : 0;
                e.res = W'(p);
                e.hi  = W'(p >> W);
                c = MUL_EN && (e.hi != 0);
                v = c;
            end
        endcase
        z = (o == 7) ? (p == 0) : (e.res == 0);
        e.flags = {c, v, e.res[W-1], z};
        return e;
    endfunction

    // Timing model: an accepted op completes after a fixed number of enabled edges.
    int           rem     = 0;
    exp_t         pend    = '0;
    logic [W-1:0] m_acc   = '0;
    logic [W-1:0] e_res   = '0;
    logic [W-1:0] e_hi    = '0;
    logic [3:0]   e_flags = '0;
    logic         e_busy  = 1'b0;
    logic         e_done  = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem <= 0; m_acc <= '0; e_res <= '0; e_hi <= '0;
            e_flags <= '0; e_busy <= 1'b0; e_done <= 1'b0;
        end else if (ena) begin
            e_done <= 1'b0;
            if (rem > 0) begin
                rem <= rem - 1;
                if (rem == 1) begin
                    e_res   <= pend.res;
                    e_hi    <= pend.hi;
                    e_flags <= pend.flags;
                    m_acc   <= pend.res;
                    e_done  <= 1'b1;
                    e_busy  <= 1'b0;
                end
            end else if (start) begin
                pend   <= ref_op(int'(op), int'(use_acc ? m_acc : a), int'(b));
                rem    <= (op == 3'd7 && MUL_EN) ? W + 1 : 1;
                e_busy <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc result",    32'(result),    32'(e_res));
            chk("cyc result_hi", 32'(result_hi), 32'(e_hi));
            chk("cyc flags",     32'(flags),     32'(e_flags));
            chk("cyc busy",      32'(busy),      32'(e_busy));
            chk("cyc done",      32'(done),      32'(e_done));
        end
    end

    // Issue one op from a negedge, wait (bounded) for done, check literals.
    task automatic run_op(input string nm, input logic [2:0] o,
                          input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic ua, input logic [W-1:0] er,
                          input logic [W-1:0] eh, input logic [3:0] ef,
                          input int eb);
        int nbusy;
        bit got;
        start = 1'b1; op = o; a = ia; b = ib; use_acc = ua;
        @(posedge clk);
        #2 start = 1'b0;
        nbusy = 0;
        got   = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (done) begin
                got = 1'b1;
                break;
            end
            if (k == poke_at)           start = 1'b1;
            if (k == poke_at + 1)       start = 1'b0;
            if (k == ena_at)            ena = 1'b0;
            if (k == ena_at + ena_len)  ena = 1'b1;
        end
        chk({nm, " done"},      32'(got),       32'd1);
        chk({nm, " result"},    32'(result),    32'(er));
        chk({nm, " result_hi"}, 32'(result_hi), 32'(eh));
        chk({nm, " flags"},     32'(flags),     32'(ef));
        chk({nm, " busy_cyc"},  32'(nbusy),     32'(eb));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst result",    32'(result),    32'h0);
        chk("rst result_hi", 32'(result_hi), 32'h0);
        chk("rst flags",     32'(flags),     32'h0);
        chk("rst busy",      32'(busy),      32'h0);
        chk("rst done",      32'(done),      32'h0);
        #1 rst_n = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);

        run_op("add_ovf",    3'd0, 8'h7F, 8'h01, 1'b0, 8'h80, 8'h00, 4'b0110, 1);
        run_op("sub_borrow", 3'd1, 8'h00, 8'h01, 1'b0, 8'hFF, 8'h00, 4'b1010, 1);
        run_op("shl_c",      3'd5, 8'h81, 8'h09, 1'b0, 8'h02, 8'h00, 4'b1000, 1);
        run_op("shr_zero",   3'd6, 8'h81, 8'h08, 1'b0, 8'h81, 8'h00, 4'b0010, 1);
        run_op("shr_c",      3'd6, 8'hC0, 8'h07, 1'b0, 8'h01, 8'h00, 4'b1000, 1);
        run_op("and",        3'd2, 8'hF0, 8'h3C, 1'b0, 8'h30, 8'h00, 4'b0000, 1);
        run_op("or",         3'd3, 8'h0F, 8'hF0, 1'b0, 8'hFF, 8'h00, 4'b0010, 1);
        run_op("xor_z",      3'd4, 8'hAA, 8'hAA, 1'b0, 8'h00, 8'h00, 4'b0001, 1);
        run_op("add_carry",  3'd0, 8'hFF, 8'h01, 1'b0, 8'h00, 8'h00, 4'b1001, 1);
        run_op("mul_ff",     3'd7, 8'hFF, 8'hFF, 1'b0,
               MUL_EN ? 8'h01 : 8'h00, MUL_EN ? 8'hFE : 8'h00,
               MUL_EN ? 4'b1100 : 4'b0001, MUL_EN ? 9 : 1);
        run_op("acc_first",  3'd0, 8'h05, 8'h03, 1'b0, 8'h08, 8'h00, 4'b0000, 1);
        run_op("acc_chain",  3'd0, 8'hEE, 8'h02, 1'b1, 8'h0A, 8'h00, 4'b0000, 1);
`ifdef ALU_SEQ_MUL_EN
        poke_at = 3;
        run_op("mul_poke",   3'd7, 8'h0F, 8'h0F, 1'b0, 8'hE1, 8'h00, 4'b0010, 9);
        poke_at = 0;
        ena_at  = 3;
        ena_len = 3;
        run_op("mul_ena",    3'd7, 8'hB7, 8'h5C, 1'b0, 8'hC4, 8'h41, 4'b1110, 12);
        ena_at  = 0;
        ena_len = 0;
`endif
        run_op("add_pre_rst", 3'd0, 8'h10, 8'h20, 1'b0, 8'h30, 8'h00, 4'b0000, 1);

`ifdef ALU_SEQ_MUL_EN
        start = 1'b1; op = 3'd7; a = 8'h12; b = 8'h34; use_acc = 1'b0;
        @(posedge clk);
        #2 start = 1'b0;
        repeat (4) @(negedge clk);
`endif
        #1 rst_n = 1'b0;
        #1;
        chk("midrst result",    32'(result),    32'h0);
        chk("midrst result_hi", 32'(result_hi), 32'h0);
        chk("midrst flags",     32'(flags),     32'h0);
        chk("midrst busy",      32'(busy),      32'h0);
        chk("midrst done",      32'(done),      32'h0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst no_done", 32'(done), 32'h0);
        end
        run_op("acc_after_rst", 3'd0, 8'h55, 8'h07, 1'b1, 8'h07, 8'h00, 4'b0000, 1);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
